vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have these parameters:
- H_VISIBLE, default 640, active pixels per line.
- H_FRONT, default 16, horizontal front porch.
- H_SYNC, default 96, horizontal sync width.
- H_BACK, default 48, horizontal back porch.
- V_VISIBLE, default 480, active lines.
- V_FRONT, default 10, vertical front porch.
- V_SYNC, default 2, vertical sync width.
- V_BACK, default 33, vertical back porch.
- SYNC_ACTIVE, default 0, asserted level of both syncs.
- TICK_LINE, default 481, line index of the frame tick.

REQ-002 The block SHALL have these ports, clock and reset first:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_pix_en  in  1  pixel-clock enable; counters advance only when high.
- o_pixel_x  out  10  current column, 0..H_TOTAL-1.
- o_pixel_y  out  10  current line, 0..V_TOTAL-1.
- o_visible_area  out  1  high while the current pixel is in the active region.
- o_hsync  out  1  horizontal sync.
- o_vsync  out  1  vertical sync.
- o_line_start  out  1  one-i_clk pulse when a new line begins.
- o_frame_tick  out  1  one-i_clk pulse once per frame, used for game-object update.
- o_frame_count  out  8  frame counter.

REQ-003 Totals SHALL be derived: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).

Function
REQ-004 h/v counters SHALL be registers driven directly to o_pixel_x/o_pixel_y; no other latency.
REQ-005 On an i_clk edge with i_pix_en=1: if h < H_TOTAL-1 then h := h+1, else h := 0 and the vertical step is taken.
REQ-006 Vertical step: if v < V_TOTAL-1 then v := v+1, else v := 0 and o_frame_count := o_frame_count+1, wrapping 255->0.
REQ-007 With i_pix_en=0, all counters and all level outputs SHALL hold their values.
REQ-008 o_visible_area SHALL be 1 iff h < H_VISIBLE and v < V_VISIBLE, and SHALL be consistent with o_pixel_x/o_pixel_y in the same cycle.
REQ-009 o_hsync SHALL be SYNC_ACTIVE iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE.
REQ-010 o_vsync SHALL be SYNC_ACTIVE iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491), else ~SYNC_ACTIVE.
REQ-011 Sync outputs SHALL be same-cycle consistent with the counters and glitch-free: either registered from next-counter values or decoded from registers only.
REQ-012 o_frame_tick SHALL be high for exactly one i_clk cycle: the first cycle in which (h,v) = (0,TICK_LINE).
REQ-012a o_frame_tick SHALL NOT reassert while (h,v) is held at (0,TICK_LINE) by i_pix_en=0.
REQ-012b Implementation of REQ-012: an armed flag, cleared on pulse and rearmed when (h,v) leaves (0,TICK_LINE).
REQ-013 o_line_start SHALL follow the same one-i_clk-pulse rule as REQ-012, at every h = 0 (every line, including v = 0).
REQ-014 If TICK_LINE >= V_TOTAL, o_frame_tick SHALL never assert; no other behaviour changes.
REQ-015 Arithmetic SHALL be 10-bit unsigned and SHALL not overflow for the default parameters; wrap SHALL occur only via the compare in REQ-005/REQ-006.

Reset
REQ-016 While i_reset=1, all outputs SHALL take these values, irrespective of i_clk and i_pix_en:
- h = 0, v = 0.
- o_frame_count = 0.
- o_visible_area = 1.
- o_hsync = o_vsync = ~SYNC_ACTIVE.
- o_line_start = 0, o_frame_tick = 0.
- tick flags armed.
REQ-017 At reset assertion mid-line or mid-frame, the block SHALL take the REQ-016 values immediately (asynchronously).
REQ-018 No o_line_start pulse SHALL occur for the (0,0) position present at reset; the first o_line_start SHALL occur at the first h wrap after reset.
REQ-019 Counting SHALL resume at the first i_clk edge after deassertion with i_pix_en=1.

Verification
REQ-020 i_pix_en=1 every cycle, 2 frames -> 800 cycles per line, 525 lines per frame; o_frame_count 0->1->2; o_hsync low exactly at h 656..751; o_vsync low exactly at v 490..491.
REQ-021 i_pix_en=1 every 2nd cycle -> each (h,v) held for 2 cycles; o_frame_tick high for exactly 1 cycle at (0,481); o_line_start high for exactly 1 cycle per line.
REQ-022 Visible boundary -> (639,479) o_visible_area=1; (640,479) =0; (0,480) =0; (799,524)->(0,0) =1.
REQ-023 i_pix_en held 0 for 50 cycles while at (0,481) -> o_frame_tick pulses once; all outputs frozen; counting resumes on re-enable.
REQ-024 i_reset pulsed mid-cycle at (700,300) with o_frame_count=7 -> outputs immediately (0,0), count 0, syncs inactive; no o_line_start until h wraps.
REQ-025 Wrap with o_frame_count=255 at (799,524) -> next enabled edge gives (0,0) and o_frame_count=0.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: parameterised VGA raster counters with sync, visible-area,
// line-start and once-per-frame tick generation.
`default_nettype none

module vga_timing #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned TICK_LINE   = 481
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pix_en,
  output logic [9:0] o_pixel_x,
  output logic [9:0] o_pixel_y,
  output logic       o_visible_area,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_line_start,
  output logic       o_frame_tick,
  output logic [7:0] o_frame_count
);

  localparam int unsigned C_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned C_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] C_H_MAX      = 10'(C_H_TOTAL - 1);
  localparam logic [9:0] C_V_MAX      = 10'(C_V_TOTAL - 1);
  localparam logic [9:0] C_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] C_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] C_HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] C_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] C_VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] C_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  // An out-of-range tick line disables the frame tick entirely.
  localparam bit         C_TICK_EN    = (TICK_LINE < C_V_TOTAL);
  localparam logic [9:0] C_TICK_V     = 10'(TICK_LINE);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       line_start_q, line_start_d;
  logic       frame_tick_q;
  logic       tick_armed_q;
  logic       at_tick_d;

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frame_count_d = frame_count_q;
    if (i_pix_en) begin
      if (h_q < C_H_MAX) begin
        h_d = h_q + 10'd1;
      end else begin
        h_d = 10'd0;
        if (v_q < C_V_MAX) begin
          v_d = v_q + 10'd1;
        end else begin
          v_d           = 10'd0;
          frame_count_d = frame_count_q + 8'd1;
        end
      end
    end
  end

  // A line starts only through a wrap, so the (0,0) left by reset never pulses.
  assign line_start_d = i_pix_en && (h_q >= C_H_MAX);
  assign at_tick_d    = C_TICK_EN && (h_d == 10'd0) && (v_d == C_TICK_V);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      frame_count_q <= 8'd0;
      line_start_q  <= 1'b0;
      frame_tick_q  <= 1'b0;
      tick_armed_q  <= 1'b1;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_count_q <= frame_count_d;
      line_start_q  <= line_start_d;
      frame_tick_q  <= at_tick_d && tick_armed_q;
      // Disarm while parked on the tick position; rearm once it moves on.
      tick_armed_q  <= !at_tick_d;
    end
  end

  assign o_pixel_x      = h_q;
  assign o_pixel_y      = v_q;
  assign o_frame_count  = frame_count_q;
  assign o_line_start   = line_start_q;
  assign o_frame_tick   = frame_tick_q;
  assign o_visible_area = (h_q < C_H_VIS) && (v_q < C_V_VIS);
  assign o_hsync = ((h_q >= C_HS_START) && (h_q < C_HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign o_vsync = ((v_q >= C_VS_START) && (v_q < C_VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: reduced raster, scoreboard model plus boundary table.
`default_nettype none

module tb_vga_timing;
  localparam int HV = 8, HF = 1, HS = 2, HB = 1;
  localparam int VV = 6, VF = 1, VS = 1, VB = 2;
  localparam int HT = HV + HF + HS + HB;  // 12
  localparam int VT = VV + VF + VS + VB;  // 10
  localparam int TL = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] px, py, px2, py2;
  logic [7:0] fc, fc2;
  logic       vis, hs, vs, ls, ft;
  logic       vis2, hs2, vs2, ls2, ft2;

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0), .TICK_LINE(TL)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_pix_en(en),
    .o_pixel_x(px), .o_pixel_y(py), .o_visible_area(vis),
    .o_hsync(hs), .o_vsync(vs), .o_line_start(ls),
    .o_frame_tick(ft), .o_frame_count(fc)
  );

  // Same raster, active-high syncs, tick line out of range.
  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b1), .TICK_LINE(VT)
  ) dut2 (
    .i_clk(clk), .i_reset(rst), .i_pix_en(en),
    .o_pixel_x(px2), .o_pixel_y(py2), .o_visible_area(vis2),
    .o_hsync(hs2), .o_vsync(vs2), .o_line_start(ls2),
    .o_frame_tick(ft2), .o_frame_count(fc2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, v, f;
    bit vis, hs, vs, ls, ft;
  } exp_t;

  typedef struct {
    int h, v;
    bit vis, hs, vs;
  } bnd_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   mh = 0, mv = 0, mfc = 0;
  bit   m_prev_at = 1'b0;
  int   ls_count = 0, ft_count = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (model pos %0d,%0d)", nm, act, exp, mh, mv);
    end
  endtask

  task automatic step(input bit e);
    exp_t x;
    bit   wrap, at;
    en   = e;
    wrap = e && (mh == HT - 1);
    if (e) begin
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv  = 0;
          mfc = (mfc + 1) % 256;
        end else mv++;
      end else mh++;
    end
    at        = (mh == 0) && (mv == TL);
    x.h       = mh;
    x.v       = mv;
    x.f       = mfc;
    x.vis     = (mh < HV) && (mv < VV);
    x.hs      = !((mh >= HV + HF) && (mh < HV + HF + HS));
    x.vs      = !((mv >= VV + VF) && (mv < VV + VF + VS));
    x.ls      = wrap;
    x.ft      = at && !m_prev_at;
    m_prev_at = at;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("pixel_x", int'(px), x.h);
    check("pixel_y", int'(py), x.v);
    check("frame_count", int'(fc), x.f);
    check("visible", int'(vis), int'(x.vis));
    check("hsync", int'(hs), int'(x.hs));
    check("vsync", int'(vs), int'(x.vs));
    check("line_start", int'(ls), int'(x.ls));
    check("frame_tick", int'(ft), int'(x.ft));
    check("hsync_pos_pol", int'(hs2), int'(!x.hs));
    check("tick_out_of_range", int'(ft2), 0);
    ls_count += int'(ls);
    ft_count += int'(ft);
  endtask

  task automatic advance_to(input int th, input int tv, input int tfc, input int bound);
    int n = 0;
    while (!(mh == th && mv == tv && (tfc < 0 || mfc == tfc)) && n < bound) begin
      step(1'b1);
      n++;
    end
    if (!(mh == th && mv == tv && (tfc < 0 || mfc == tfc))) begin
      total++;
      bad++;
      $display("FAIL advance_timeout: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", mh, mv, mfc, th, tv, tfc);
    end
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_x"}, int'(px), 0);
    check({nm, "_y"}, int'(py), 0);
    check({nm, "_fc"}, int'(fc), 0);
    check({nm, "_vis"}, int'(vis), 1);
    check({nm, "_hs"}, int'(hs), 1);
    check({nm, "_vs"}, int'(vs), 1);
    check({nm, "_ls"}, int'(ls), 0);
    check({nm, "_ft"}, int'(ft), 0);
    check({nm, "_hs2"}, int'(hs2), 0);
  endtask

  bnd_t bt[8];

  initial begin
    bt[0] = '{h: 7,  v: 5, vis: 1, hs: 1, vs: 1};
    bt[1] = '{h: 8,  v: 5, vis: 0, hs: 1, vs: 1};
    bt[2] = '{h: 0,  v: 6, vis: 0, hs: 1, vs: 1};
    bt[3] = '{h: 9,  v: 7, vis: 0, hs: 0, vs: 0};
    bt[4] = '{h: 10, v: 7, vis: 0, hs: 0, vs: 0};
    bt[5] = '{h: 11, v: 7, vis: 0, hs: 1, vs: 0};
    bt[6] = '{h: 0,  v: 8, vis: 0, hs: 1, vs: 1};
    bt[7] = '{h: 0,  v: 0, vis: 1, hs: 1, vs: 1};

    rst = 1'b0;
    en  = 1'b0;
    #2 rst = 1'b1;
    #2 check_reset_values("rst_async");
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_values("rst_held");
    rst = 1'b0;

    // Two frames at full rate
    ls_count = 0;
    ft_count = 0;
    repeat (2 * HT * VT) step(1'b1);
    check("two_frames_fc", int'(fc), 2);
    check("two_frames_ls", ls_count, 2 * VT);
    check("two_frames_ft", ft_count, 2);

    // One frame with enable every second cycle
    ls_count = 0;
    ft_count = 0;
    for (int i = 0; i < 2 * HT * VT; i++) step(i % 2 == 0);
    check("half_rate_ls", ls_count, VT);
    check("half_rate_ft", ft_count, 1);

    for (int i = 0; i < 8; i++) begin
      advance_to(bt[i].h, bt[i].v, -1, 2 * HT * VT);
      check("bnd_vis", int'(vis), int'(bt[i].vis));
      check("bnd_hs", int'(hs), int'(bt[i].hs));
      check("bnd_vs", int'(vs), int'(bt[i].vs));
    end

    // Park on the tick position with enable low
    ft_count = 0;
    advance_to(0, TL, -1, 2 * HT * VT);
    repeat (50) step(1'b0);
    check("freeze_ft_once", ft_count, 1);
    check("freeze_x", int'(px), 0);
    check("freeze_y", int'(py), TL);
    step(1'b1);
    check("resume_x", int'(px), 1);

    // Asynchronous reset mid-line inside hsync
    advance_to(9, 5, 7, 10 * HT * VT);
    check("pre_reset_fc", int'(fc), 7);
    check("pre_reset_hs", int'(hs), 0);
    #3 rst = 1'b1;
    #1 check_reset_values("rst_mid");
    mh = 0; mv = 0; mfc = 0; m_prev_at = 1'b0;
    @(posedge clk);
    #1 check_reset_values("rst_mid_held");
    rst = 1'b0;
    ls_count = 0;
    repeat (HT - 1) step(1'b1);
    check("no_ls_before_wrap", ls_count, 0);
    step(1'b1);
    check("first_ls_at_wrap", int'(ls), 1);

    // Frame counter wrap 255 -> 0
    advance_to(HT - 1, VT - 1, 255, 260 * HT * VT);
    check("pre_wrap_fc", int'(fc), 255);
    step(1'b1);
    check("wrap_x", int'(px), 0);
    check("wrap_y", int'(py), 0);
    check("wrap_fc", int'(fc), 0);
    check("wrap_vis", int'(vis), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
